// File: rtl/eth_frame_hdr_pkg.sv
// -----------------------------------------------------------------------------
// eth_frame_hdr_pkg
//   Shared definitions for the per-frame Ethernet header writer.
//   - state_t    : controller states (IDLE, HDR, START, WAIT_IDLE)
//   - HDR_LEN    : bytes in the Ethernet header (dst MAC, src MAC, ethertype)
//   - SEQ_W      : width of the frame sequence number
//   - NUM_WRITES : header bytes plus the two sequence-number bytes
//   - sat_inc8   : saturating 8-bit increment used by the event counters
// -----------------------------------------------------------------------------
package eth_frame_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HDR       = 2'd1,
        START     = 2'd2,
        WAIT_IDLE = 2'd3
    } state_t;

    localparam int HDR_LEN    = 14;
    localparam int SEQ_W      = 16;
    localparam int NUM_WRITES = HDR_LEN + 2;
    localparam int IDX_W      = $clog2(NUM_WRITES);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/eth_frame_hdr.sv
// -----------------------------------------------------------------------------
// eth_frame_hdr
//   Writes the 14-byte Ethernet header plus a 16-bit sequence number into the
//   frame BRAM when the PCM fill logic signals a complete payload, then kicks
//   the Ethernet transmitter and follows its busy flag until the frame is out.
//
//   Handshake: frame_ready is a single-cycle strobe that is only honoured in
//   IDLE (anywhere else it is counted as an overrun and dropped); eth_start is
//   a level request held until eth_tx_busy is sampled high or the start timer
//   expires; frame_done is a single-cycle strobe once eth_tx_busy falls.
//
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     frame_ready        payload complete strobe from the fill logic
//     eth_tx_busy        transmitter busy level
//     bram_wr_en/addr/data  header write port into the frame BRAM
//     eth_start          transmit request
//     frame_done         frame finished strobe
//     busy               controller not idle
//     seq                sequence number of the last frame started
//     overrun_cnt        dropped frame_ready strobes (saturating)
//     timeout_cnt        start timeouts (saturating)
//
//   Every output comes from a flop, so no input reaches an output in the same
//   cycle.
// -----------------------------------------------------------------------------
module eth_frame_hdr
    import eth_frame_hdr_pkg::*;
#(
    parameter int          ADDR_W        = 10,
    parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC       = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE     = 16'h88B5,
    parameter int          SEQ_ADDR      = 14,
    parameter int          START_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_ready,
    input  logic              eth_tx_busy,
    output logic              bram_wr_en,
    output logic [ADDR_W-1:0] bram_wr_addr,
    output logic [7:0]        bram_wr_data,
    output logic              eth_start,
    output logic              frame_done,
    output logic              busy,
    output logic [SEQ_W-1:0]  seq,
    output logic [7:0]        overrun_cnt,
    output logic [7:0]        timeout_cnt
);

    localparam int               TMR_W    = $clog2(START_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WRITES - 1);

    state_t              state, state_nx;
    logic [IDX_W-1:0]    idx, idx_nx;         // byte currently on the write port
    logic [TMR_W-1:0]    timer, timer_nx;
    logic [SEQ_W-1:0]    seq_cnt, seq_cnt_nx; // resets to all-ones so frame 0 carries 0
    logic                wr_en_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [7:0]          data_nx;
    logic                frame_done_nx;
    logic [SEQ_W-1:0]    seq_nx;
    logic [7:0]          overrun_nx;
    logic [7:0]          timeout_nx;

    // Sequence bytes may live anywhere; header bytes are always at 0..13.
    function automatic logic [ADDR_W-1:0] byte_addr(input logic [IDX_W-1:0] i);
        logic [ADDR_W-1:0] a;
        if (i == IDX_W'(HDR_LEN))
            a = ADDR_W'(SEQ_ADDR);
        else if (i == IDX_W'(HDR_LEN + 1))
            a = ADDR_W'(SEQ_ADDR + 1);
        else
            a = ADDR_W'(i);
        return a;
    endfunction

    // 16-entry header byte select, MSB byte of each field first.
    function automatic logic [7:0] byte_data(input logic [IDX_W-1:0] i,
                                             input logic [SEQ_W-1:0] s);
        logic [7:0] d;
        case (i)
            4'd0:    d = DST_MAC[47:40];
            4'd1:    d = DST_MAC[39:32];
            4'd2:    d = DST_MAC[31:24];
            4'd3:    d = DST_MAC[23:16];
            4'd4:    d = DST_MAC[15:8];
            4'd5:    d = DST_MAC[7:0];
            4'd6:    d = SRC_MAC[47:40];
            4'd7:    d = SRC_MAC[39:32];
            4'd8:    d = SRC_MAC[31:24];
            4'd9:    d = SRC_MAC[23:16];
            4'd10:   d = SRC_MAC[15:8];
            4'd11:   d = SRC_MAC[7:0];
            4'd12:   d = ETHERTYPE[15:8];
            4'd13:   d = ETHERTYPE[7:0];
            4'd14:   d = s[15:8];
            4'd15:   d = s[7:0];
            default: d = 8'h00;
        endcase
        return d;
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            timer        <= '0;
            seq_cnt      <= '1;
            bram_wr_en   <= 1'b0;
            bram_wr_addr <= '0;
            bram_wr_data <= '0;
            frame_done   <= 1'b0;
            seq          <= '0;
            overrun_cnt  <= '0;
            timeout_cnt  <= '0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            timer        <= timer_nx;
            seq_cnt      <= seq_cnt_nx;
            bram_wr_en   <= wr_en_nx;
            bram_wr_addr <= addr_nx;
            bram_wr_data <= data_nx;
            frame_done   <= frame_done_nx;
            seq          <= seq_nx;
            overrun_cnt  <= overrun_nx;
            timeout_cnt  <= timeout_nx;
        end
    end

    // Next state. A busy transmitter wins over a simultaneous timer expiry.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (frame_ready) state_nx = HDR;
            HDR:       if (idx == IDX_LAST) state_nx = START;
            START: begin
                if (eth_tx_busy)            state_nx = WAIT_IDLE;
                else if (timer == TMR_LAST) state_nx = IDLE;
            end
            WAIT_IDLE: if (!eth_tx_busy) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath counters.
    always_comb begin
        idx_nx        = idx;
        timer_nx      = timer;
        seq_cnt_nx    = seq_cnt;
        seq_nx        = seq;
        wr_en_nx      = 1'b0;
        addr_nx       = bram_wr_addr;
        data_nx       = bram_wr_data;
        frame_done_nx = 1'b0;
        timeout_nx    = timeout_cnt;
        overrun_nx    = (frame_ready && (state != IDLE)) ? sat_inc8(overrun_cnt)
                                                         : overrun_cnt;
        case (state)
            IDLE: begin
                if (frame_ready) begin
                    seq_cnt_nx = seq_cnt + 16'd1;
                    seq_nx     = seq_cnt_nx;
                    idx_nx     = '0;
                    wr_en_nx   = 1'b1;
                    addr_nx    = byte_addr('0);
                    data_nx    = byte_data('0, seq_cnt_nx);
                end
            end
            HDR: begin
                if (idx == IDX_LAST) begin
                    timer_nx = '0;
                end else begin
                    idx_nx   = idx + IDX_W'(1);
                    wr_en_nx = 1'b1;
                    addr_nx  = byte_addr(idx_nx);
                    data_nx  = byte_data(idx_nx, seq_cnt);
                end
            end
            START: begin
                if (!eth_tx_busy) begin
                    if (timer == TMR_LAST)
                        timeout_nx = sat_inc8(timeout_cnt);
                    else
                        timer_nx = timer + TMR_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (!eth_tx_busy) frame_done_nx = 1'b1;
            end
            default: ;
        endcase
    end

    // Moore outputs decoded straight from the state flop.
    assign busy      = (state != IDLE);
    assign eth_start = (state == START);

endmodule

// File: doc/eth_frame_hdr.md
Name: eth_frame_hdr

Overview:
- Per-frame header writer between the PCM fill logic and the Ethernet transmitter.
- On a frame-ready strobe from the fill logic it:
  - writes the 14-byte Ethernet header into BRAM bytes 0..13;
  - writes a 16-bit frame sequence number into bytes SEQ_ADDR..SEQ_ADDR+1;
  - starts the transmitter and tracks its busy flag until the frame has gone out.
- Owns the header region of the frame BRAM's write port; PCM payload is written elsewhere.

Parameters:
- ADDR_W, 10, BRAM byte address width.
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC, written MSB byte first at address 0.
- SRC_MAC, 48'h02_00_00_00_00_01, source MAC, at addresses 6..11.
- ETHERTYPE, 16'h88B5, at addresses 12..13, MSB first.
- SEQ_ADDR, 14, byte address of the sequence number MSB.
- START_TIMEOUT, 1024, max clk cycles to wait for eth_tx_busy to rise after eth_start.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_ready  in  1  1-cycle strobe: payload complete, frame may be sent
- eth_tx_busy  in  1  transmitter busy, high while a frame is on the wire
- bram_wr_en  out  1  BRAM write enable
- bram_wr_addr  out  ADDR_W  BRAM write address
- bram_wr_data  out  8  BRAM write data
- eth_start  out  1  transmit request, held until busy is seen
- frame_done  out  1  1-cycle strobe: transmitter returned idle after this frame
- busy  out  1  high in every state except IDLE
- seq  out  16  sequence number of the last frame started
- overrun_cnt  out  8  frame_ready strobes dropped while busy, saturating
- timeout_cnt  out  8  start timeouts, saturating

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; seq = 16'hFFFF internally, so the first frame carries 0.
- IDLE: on frame_ready go to HDR with byte index 0, and increment seq (mod 2^16, FFFF wraps to 0).
- HDR: one byte per cycle, bram_wr_en = 1.
  - Addresses 0..13: header bytes.
  - Then SEQ_ADDR: seq[15:8]; SEQ_ADDR+1: seq[7:0].
  - 16 write cycles total; address and data are registered and change together.
  - After the last byte, bram_wr_en drops to 0 and the block moves to START.
- START: eth_start = 1; timer counts clk cycles.
  - eth_tx_busy = 1: eth_start goes to 0 next cycle; move to WAIT_IDLE.
  - Timer reaches START_TIMEOUT with busy still 0: eth_start goes to 0, timeout_cnt increments, move to IDLE with no frame_done.
- WAIT_IDLE: when eth_tx_busy = 0, pulse frame_done for 1 cycle and return to IDLE.
- Latency: frame_ready to first eth_start = 17 cycles (1 cycle into HDR + 16 writes).
- frame_ready in any state other than IDLE: overrun_cnt increments (saturates at 255); the strobe is otherwise ignored and never queued.
- frame_ready in the same cycle as the WAIT_IDLE→IDLE transition counts as an overrun.
- eth_tx_busy already 1 on entry to START: handshake completes after 1 cycle of eth_start.
- Reset mid-HDR or mid-START: outputs clear immediately; the partial header may remain in BRAM; the next frame rewrites it fully.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, HDR, START, WAIT_IDLE);
  - header length constant 14;
  - sequence field width 16.
- No sub-module. The header byte select is a 16-entry mux inside the block.

Test Plan:
- Default params, reset, one frame_ready:
  - 16 writes: addr 0..5 = FF; addr 6..11 = 02 00 00 00 00 01; addr 12..13 = 88 B5; addr 14..15 = 00 00;
  - eth_start rises 17 cycles after the strobe;
  - model raises busy 3 cycles later and lowers it 100 cycles later → one frame_done; seq = 0.
- Three back-to-back frames → sequence bytes 00 01, then 00 02; seq = 2.
- Preload seq to FFFF via 65536 frames (or forced) → next frame writes 00 00.
- frame_ready pulsed during HDR and during WAIT_IDLE → overrun_cnt = 2; no extra writes; no extra eth_start.
- Busy never asserts → eth_start high exactly 1024 cycles, then low; timeout_cnt = 1; no frame_done; next frame_ready is accepted.
- rst_n asserted mid-HDR (byte 7) → bram_wr_en, eth_start and busy go to 0 asynchronously; after release, a new frame writes all 16 bytes correctly with seq = 0.
